// File: rtl/pin_entry_encoder.sv
// rtl/pin_entry_encoder.sv - keypad front end: collects two BCD digits, presents them to the locker, reports its status
module pin_entry_encoder #(
  parameter int unsigned HOLD_CYCLES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter logic [7:0]  IDLE_CODE      = 8'hFF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic [1:0] lock_status,
  output logic [7:0] x_out,
  output logic       x_valid,
  output logic       busy,
  output logic [1:0] digit_count,
  output logic       result_valid,
  output logic [1:0] result,
  output logic       key_error,
  output logic       timeout
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST    = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ONE,
    S_TWO,
    S_SUBMIT
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    units_q, units_d;
  logic [TW-1:0] inact_q, inact_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    result_q, result_d;
  logic          result_valid_q, result_valid_d;
  logic          key_error_q, key_error_d;
  logic          timeout_q, timeout_d;

  logic is_digit, is_clear, is_enter, inact_expired;

  assign is_digit      = (key_code <= 4'd9);
  assign is_clear      = (key_code == 4'hA);
  assign is_enter      = (key_code == 4'hB);
  assign inact_expired = (inact_q == TIMEOUT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      tens_q         <= 4'd0;
      units_q        <= 4'd0;
      inact_q        <= '0;
      hold_q         <= '0;
      result_q       <= 2'b00;
      result_valid_q <= 1'b0;
      key_error_q    <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      tens_q         <= tens_d;
      units_q        <= units_d;
      inact_q        <= inact_d;
      hold_q         <= hold_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      key_error_q    <= key_error_d;
      timeout_q      <= timeout_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    tens_d         = tens_q;
    units_d        = units_q;
    inact_d        = inact_q;
    hold_d         = hold_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    key_error_d    = 1'b0;
    timeout_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        inact_d = '0;
        if (key_valid) begin
          if (is_digit) begin
            tens_d  = key_code;
            state_d = S_ONE;
          end else if (is_clear) begin
            tens_d  = 4'd0;
            units_d = 4'd0;
          end else begin
            key_error_d = 1'b1;
          end
        end
      end

      S_ONE: begin
        if (key_valid) begin
          // Any key, accepted or not, restarts the inactivity window.
          inact_d = '0;
          if (is_digit) begin
            units_d = key_code;
            state_d = S_TWO;
          end else if (is_clear) begin
            tens_d  = 4'd0;
            units_d = 4'd0;
            state_d = S_IDLE;
          end else begin
            key_error_d = 1'b1;
          end
        end else if (inact_expired) begin
          timeout_d = 1'b1;
          tens_d    = 4'd0;
          units_d   = 4'd0;
          inact_d   = '0;
          state_d   = S_IDLE;
        end else begin
          inact_d = inact_q + TW'(1);
        end
      end

      S_TWO: begin
        if (key_valid) begin
          inact_d = '0;
          if (is_clear) begin
            tens_d  = 4'd0;
            units_d = 4'd0;
            state_d = S_IDLE;
          end else if (is_enter) begin
            hold_d  = '0;
            state_d = S_SUBMIT;
          end else begin
            key_error_d = 1'b1;
          end
        end else if (inact_expired) begin
          timeout_d = 1'b1;
          tens_d    = 4'd0;
          units_d   = 4'd0;
          inact_d   = '0;
          state_d   = S_IDLE;
        end else begin
          inact_d = inact_q + TW'(1);
        end
      end

      S_SUBMIT: begin
        inact_d = '0;
        // Keys are deliberately ignored here; the locker owns the bus until the window closes.
        if (hold_q == HOLD_LAST) begin
          result_d       = lock_status;
          result_valid_d = 1'b1;
          tens_d         = 4'd0;
          units_d        = 4'd0;
          hold_d         = '0;
          state_d        = S_IDLE;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    digit_count = 2'd0;
    case (state_q)
      S_ONE:    digit_count = 2'd1;
      S_TWO:    digit_count = 2'd2;
      S_SUBMIT: digit_count = 2'd2;
      default:  digit_count = 2'd0;
    endcase
  end

  assign x_out        = (state_q == S_SUBMIT) ? {tens_q, units_q} : IDLE_CODE;
  assign x_valid      = (state_q == S_SUBMIT);
  assign busy         = (state_q == S_SUBMIT);
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign key_error    = key_error_q;
  assign timeout      = timeout_q;

endmodule
